lif_slot_scheduler: RTL and testbench
=====================================

# lif_slot_scheduler

Sequences the time-multiplexed LIF neuron datapath across N_CH cochlear channels. Each input sample from the IHC sample store is assigned one fixed-length slot per channel. Per slot the block issues the neuron-state buffer read, the datapath load strobe, the state write-back and the spike capture. It sits between the IHC sample source and the shared LIF core/state buffer, and replaces the free-running cycle/section counters used in bench-level bring-up.

## Interface
Parameters:
- N_CH, 50: channels (sections) per frame
- SLOT_CYC, 16: cycles per channel slot; must be ≥ PIPE_LAT+3
- PIPE_LAT, 3: cycles from lif_load to write-back data valid
- BUF_AW, 10: LIF state buffer address width
- SMP_AW, 24: sample address width
- SMP_DEPTH, 3000000: sample store depth (50×60000)

Ports:
- clk_in  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  run frames; sampled only in IDLE and at frame end
- smp_valid  in  1  sample for next slot available
- smp_ready  out  1  sample consumed this cycle (valid&ready handshake)
- smp_addr  out  SMP_AW  sample-store address for the current/next slot
- LIF_buf_raddr  out  BUF_AW  state read address (= channel)
- LIF_buf_waddr  out  BUF_AW  state write address
- LIF_buf_wren  out  1  state write strobe
- lif_load  out  1  datapath latches state and syn input
- post_spike  in  1  spike flag from LIF core, valid in the write-back cycle
- spike_valid  out  1  registered spike event
- spike_ch  out  7  channel of spike_valid
- frame_done  out  1  one-cycle pulse after last channel's slot
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WAIT, SLOT. Registers: ch (0..N_CH-1), cyc (0..SLOT_CYC-1), smp_addr.
- IDLE: all strobes 0. enable=1 → WAIT, ch=0.
- WAIT: smp_ready = smp_valid. If smp_valid → SLOT with cyc=0. Otherwise hold; no buffer access.
- SLOT, by cyc:
  - 0: LIF_buf_raddr = ch (held during the whole slot).
  - 1: lif_load = 1.
  - 1+PIPE_LAT: LIF_buf_wren = 1, LIF_buf_waddr = ch; post_spike sampled.
  - Spike: if post_spike is 1, spike_valid = 1 and spike_ch = ch on the next cycle.
- SLOT at cyc = SLOT_CYC-1, slot end:
  - smp_addr increments; SMP_DEPTH-1 wraps to 0.
  - If ch < N_CH-1: ch++. If smp_valid, smp_ready=1 and go directly to SLOT cyc 0 (no bubble); otherwise go to WAIT.
  - If ch = N_CH-1: ch=0 and frame_done=1 next cycle. Then enable=0 → IDLE; enable=1 behaves as the ch < N_CH-1 case.
- enable deasserted mid-frame: the frame always completes before IDLE.
- Exactly one smp_ready, one lif_load and one LIF_buf_wren per slot, in that order.

## Timing
- Reset values: all outputs 0, ch=0, cyc=0, smp_addr=0, state IDLE. Reset applies immediately, asynchronously.
- Reset mid-slot drops any pending write-back. The state buffer contents are not cleared.
- Sample latency: enable at edge t → WAIT at t+1 (smp_ready at t+1 if valid) → SLOT cyc 0 at t+2.
- Write latency: lif_load at t+3, wren at t+3+PIPE_LAT.
- Throughput with continuous smp_valid: one channel per SLOT_CYC cycles, i.e. frame = N_CH×SLOT_CYC = 800 cycles.
- spike_valid lags wren by exactly 1 cycle. frame_done lags the last slot's final cycle by 1.

## Structure
- Shared package lif_pkg:
  - state enum (IDLE/WAIT/SLOT)
  - default N_CH, SLOT_CYC, PIPE_LAT, SMP_DEPTH
  - CH_W = $clog2(N_CH)
- One sub-module, lif_slot_timer:
  - holds the cyc counter
  - decodes the load/wb/last strobes from cyc and PIPE_LAT
- The FSM, channel counter and address generation stay in the top.

## Test plan
- Reset, then enable=1 with smp_valid=1 at edge t → smp_ready at t+1, raddr=0 at t+2, lif_load at t+3, wren with waddr=0 at t+6.
- Continuous valid for one frame → 50 smp_ready pulses spaced 16 cycles apart, smp_addr 0→50, single frame_done ~800 cycles after start, second frame begins with no bubble.
- smp_valid held low for 5 cycles before channel 7 → FSM stays in WAIT 5 cycles, no wren/lif_load, channel 7 resumes with raddr=7.
- post_spike=1 only in channel 12's write-back cycle → exactly one spike_valid with spike_ch=12, one cycle after that wren.
- enable dropped during channel 20 → channels 20..49 still complete, frame_done pulses, busy=0 next cycle, no further smp_ready.
- SMP_DEPTH=60 override, run 2 frames → smp_addr goes 59→0. Assert reset mid-slot at cyc 2 → all outputs 0 immediately and no wren after release until a new enable.

Source files
------------

// File: rtl/lif_pkg.sv
// ============================================================================
//  lif_pkg
//  Shared state encoding and default sizing for the LIF slot scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SLOT = 2'd2
    } lif_state_e;

    localparam int c_N_CH      = 50;
    localparam int c_SLOT_CYC  = 16;
    localparam int c_PIPE_LAT  = 3;
    localparam int c_SMP_DEPTH = 3000000;
    localparam int c_CH_W      = $clog2(c_N_CH);

endpackage

`default_nettype wire

// File: rtl/lif_slot_timer.sv
// ============================================================================
//  lif_slot_timer
//  Per-slot cycle counter with load / write-back / last-cycle strobe decode.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lif_slot_timer
    import lif_pkg::*;
#(
    parameter int SLOT_CYC = c_SLOT_CYC,
    parameter int PIPE_LAT = c_PIPE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_load,
    output logic o_wb,
    output logic o_last
);

    localparam int                c_CYC_W    = $clog2(SLOT_CYC);
    localparam logic [c_CYC_W-1:0] c_CYC_ONE  = c_CYC_W'(1);
    localparam logic [c_CYC_W-1:0] c_WB_CYC   = c_CYC_W'(PIPE_LAT + 1);
    localparam logic [c_CYC_W-1:0] c_LAST_CYC = c_CYC_W'(SLOT_CYC - 1);

    logic [c_CYC_W-1:0] cyc_q;
    logic [c_CYC_W-1:0] cyc_d;

    assign o_load = i_run && (cyc_q == c_CYC_ONE);
    assign o_wb   = i_run && (cyc_q == c_WB_CYC);
    assign o_last = i_run && (cyc_q == c_LAST_CYC);

    // Counter parks at zero outside a slot so every slot starts from cyc 0.
    always_comb begin
        cyc_d = '0;
        if (i_run && !o_last) begin
            cyc_d = cyc_q + c_CYC_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lif_slot_scheduler.sv
// ============================================================================
//  lif_slot_scheduler
//  Sequences the shared LIF datapath through one fixed-length slot per channel.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lif_slot_scheduler
    import lif_pkg::*;
#(
    parameter int N_CH      = c_N_CH,
    parameter int SLOT_CYC  = c_SLOT_CYC,
    parameter int PIPE_LAT  = c_PIPE_LAT,
    parameter int BUF_AW    = 10,
    parameter int SMP_AW    = 24,
    parameter int SMP_DEPTH = c_SMP_DEPTH
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              smp_valid,
    output logic              smp_ready,
    output logic [SMP_AW-1:0] smp_addr,
    output logic [BUF_AW-1:0] LIF_buf_raddr,
    output logic [BUF_AW-1:0] LIF_buf_waddr,
    output logic              LIF_buf_wren,
    output logic              lif_load,
    input  logic              post_spike,
    output logic              spike_valid,
    output logic [6:0]        spike_ch,
    output logic              frame_done,
    output logic              busy
);

    localparam int                   c_CH_BITS   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [c_CH_BITS-1:0] c_LAST_CH   = c_CH_BITS'(N_CH - 1);
    localparam logic [c_CH_BITS-1:0] c_CH_ONE    = c_CH_BITS'(1);
    localparam logic [SMP_AW-1:0]    c_LAST_ADDR = SMP_AW'(SMP_DEPTH - 1);
    localparam logic [SMP_AW-1:0]    c_ADDR_ONE  = SMP_AW'(1);

    lif_state_e           state_q,       state_d;
    logic [c_CH_BITS-1:0] ch_q,          ch_d;
    logic [SMP_AW-1:0]    smp_addr_q,    smp_addr_d;
    logic                 spike_valid_q, spike_valid_d;
    logic [6:0]           spike_ch_q,    spike_ch_d;
    logic                 frame_done_q,  frame_done_d;

    logic slot_run;
    logic slot_load;
    logic slot_wb;
    logic slot_last;
    logic continue_run;

    assign slot_run = (state_q == ST_SLOT);

    lif_slot_timer #(
        .SLOT_CYC (SLOT_CYC),
        .PIPE_LAT (PIPE_LAT)
    ) u_timer (
        .clk    (clk_in),
        .rst    (reset),
        .i_run  (slot_run),
        .o_load (slot_load),
        .o_wb   (slot_wb),
        .o_last (slot_last)
    );

    assign smp_addr      = smp_addr_q;
    assign LIF_buf_raddr = BUF_AW'(ch_q);
    assign LIF_buf_waddr = slot_wb ? BUF_AW'(ch_q) : '0;
    assign LIF_buf_wren  = slot_wb;
    assign lif_load      = slot_load;
    assign spike_valid   = spike_valid_q;
    assign spike_ch      = spike_ch_q;
    assign frame_done    = frame_done_q;
    assign busy          = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        smp_addr_d    = smp_addr_q;
        spike_valid_d = 1'b0;
        spike_ch_d    = spike_ch_q;
        frame_done_d  = 1'b0;
        smp_ready     = 1'b0;
        continue_run  = 1'b0;

        if (slot_wb && post_spike) begin
            spike_valid_d = 1'b1;
            spike_ch_d    = 7'(ch_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                    ch_d    = '0;
                end
            end
            ST_WAIT: begin
                smp_ready = smp_valid;
                if (smp_valid) begin
                    state_d = ST_SLOT;
                end
            end
            ST_SLOT: begin
                if (slot_last) begin
                    smp_addr_d = (smp_addr_q == c_LAST_ADDR) ? '0 : smp_addr_q + c_ADDR_ONE;
                    // Enable only matters at a frame boundary; mid-frame slots always continue.
                    if (ch_q == c_LAST_CH) begin
                        ch_d         = '0;
                        frame_done_d = 1'b1;
                        continue_run = enable;
                    end else begin
                        ch_d         = ch_q + c_CH_ONE;
                        continue_run = 1'b1;
                    end
                    if (continue_run) begin
                        smp_ready = smp_valid;
                        state_d   = smp_valid ? ST_SLOT : ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            smp_addr_q    <= '0;
            spike_valid_q <= 1'b0;
            spike_ch_q    <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            smp_addr_q    <= smp_addr_d;
            spike_valid_q <= spike_valid_d;
            spike_ch_q    <= spike_ch_d;
            frame_done_q  <= frame_done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lif_slot_scheduler.sv
// ============================================================================
//  tb_lif_slot_scheduler
//  Directed and randomized checks of the slot scheduler against an event model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lif_slot_scheduler;
    import lif_pkg::*;

    localparam int N       = c_N_CH;
    localparam int SC      = c_SLOT_CYC;
    localparam int P       = c_PIPE_LAT;
    localparam int DEPTH   = c_SMP_DEPTH;
    localparam int DEPTH_W = 60;

    logic clk_in = 1'b0, reset = 1'b0, enable = 1'b0, smp_valid = 1'b0, post_spike = 1'b0;

    logic        smp_ready, wren, lif_load, spike_valid, frame_done, busy;
    logic [23:0] smp_addr;
    logic [9:0]  raddr, waddr;
    logic [6:0]  spike_ch;

    logic        w_smp_ready, w_wren, w_lif_load, w_spike_valid, w_frame_done, w_busy;
    logic [23:0] w_smp_addr;
    logic [9:0]  w_raddr, w_waddr;
    logic [6:0]  w_spike_ch;

    lif_slot_scheduler dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .smp_valid(smp_valid),
        .smp_ready(smp_ready), .smp_addr(smp_addr), .LIF_buf_raddr(raddr),
        .LIF_buf_waddr(waddr), .LIF_buf_wren(wren), .lif_load(lif_load),
        .post_spike(post_spike), .spike_valid(spike_valid), .spike_ch(spike_ch),
        .frame_done(frame_done), .busy(busy)
    );

    lif_slot_scheduler #(.SMP_DEPTH(DEPTH_W)) dut_w (
        .clk_in(clk_in), .reset(reset), .enable(enable), .smp_valid(smp_valid),
        .smp_ready(w_smp_ready), .smp_addr(w_smp_addr), .LIF_buf_raddr(w_raddr),
        .LIF_buf_waddr(w_waddr), .LIF_buf_wren(w_wren), .lif_load(w_lif_load),
        .post_spike(post_spike), .spike_valid(w_spike_valid), .spike_ch(w_spike_ch),
        .frame_done(w_frame_done), .busy(w_busy)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int now    = 0;

    // Event-time model: each accepted sample schedules its slot's strobes.
    bit m_idle, m_cur_last;
    int m_next_ok, m_slot_end, m_load_at, m_wb_at, m_spk_at, m_fd_at;
    int m_done_inc_at, m_idle_at, m_slots_done, m_issued, m_cur_ch, m_spk_ch;

    logic        e_ready, e_load, e_wren, e_spk, e_fd, e_busy;
    logic [9:0]  e_raddr, e_waddr;
    logic [6:0]  e_spk_ch;
    logic [23:0] e_addr, e_addr_w;

    task automatic model_reset();
        m_idle = 1'b1; m_cur_last = 1'b0;
        m_next_ok = 0; m_slot_end = -1; m_load_at = -1; m_wb_at = -1;
        m_spk_at = -1; m_fd_at = -1; m_done_inc_at = -1; m_idle_at = -1;
        m_slots_done = 0; m_issued = 0; m_cur_ch = 0; m_spk_ch = 0;
    endtask

    task automatic model_eval(input bit en, input bit vld, input bit spk);
        if (now == m_done_inc_at) m_slots_done++;
        if (now == m_idle_at) m_idle = 1'b1;
        e_busy   = !m_idle;
        e_ready  = !m_idle && (now >= m_next_ok) && vld && !(now == m_slot_end && m_cur_last && !en);
        e_load   = (now == m_load_at);
        e_wren   = (now == m_wb_at);
        e_waddr  = e_wren ? 10'(m_cur_ch) : 10'd0;
        e_spk    = (now == m_spk_at);
        e_spk_ch = 7'(m_spk_ch);
        e_fd     = (now == m_fd_at);
        e_raddr  = 10'(m_slots_done % N);
        e_addr   = 24'(m_slots_done % DEPTH);
        e_addr_w = 24'(m_slots_done % DEPTH_W);
        if (m_idle && en) begin
            m_idle    = 1'b0;
            m_next_ok = now + 1;
        end
        if (spk && now == m_wb_at) begin
            m_spk_at = now + 1;
            m_spk_ch = m_cur_ch;
        end
        if (now == m_slot_end) begin
            m_done_inc_at = now + 1;
            if (m_cur_last) begin
                m_fd_at = now + 1;
                if (!en) m_idle_at = now + 1;
            end
        end
        if (e_ready) begin
            m_cur_ch   = m_issued % N;
            m_issued++;
            m_cur_last = (m_cur_ch == N - 1);
            m_load_at  = now + 2;
            m_wb_at    = now + 2 + P;
            m_slot_end = now + SC;
            m_next_ok  = now + SC;
        end
    endtask

    task automatic run_cycle(input bit en, input bit vld, input bit spk);
        @(posedge clk_in);
        #1;
        enable = en; smp_valid = vld; post_spike = spk;
        now++;
        @(negedge clk_in);
        model_eval(en, vld, spk);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        enable = 1'b0; smp_valid = 1'b0; post_spike = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(posedge clk_in);
        #1;
        reset = 1'b1; enable = 1'b1; smp_valid = 1'b1;
        #1;
        checks++; if (smp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", smp_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({lif_load, wren, spike_valid, frame_done} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {lif_load, wren, spike_valid, frame_done}); end
        checks++; if ({smp_addr, raddr, waddr, spike_ch} !== '0) begin
            errors++; $display("FAIL reset_addrs got=%h exp=0", {smp_addr, raddr, waddr, spike_ch}); end
        @(posedge clk_in);
        #1;
        reset = 1'b0; enable = 1'b0; smp_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0);
            checks++; if ({smp_ready, busy} !== 2'b00) begin
                errors++; $display("FAIL idle_no_ready got=%b exp=00", {smp_ready, busy}); end
        end
    endtask

    task automatic test_first_latency();
        int t_en = -1, r_rdy = -1, r_ld = -1, r_wr = -1, r_wa = -1, ra2 = -1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            if (i == 0) t_en = now;
            if (smp_ready && r_rdy < 0) r_rdy = now;
            if (lif_load && r_ld < 0) r_ld = now;
            if (wren && r_wr < 0) begin r_wr = now; r_wa = int'(waddr); end
            if (now == t_en + 2) ra2 = int'(raddr);
        end
        checks++; if (r_rdy !== t_en + 1) begin errors++; $display("FAIL lat_ready got=%0d exp=%0d", r_rdy, t_en + 1); end
        checks++; if (ra2 !== 0) begin errors++; $display("FAIL lat_raddr got=%0d exp=0", ra2); end
        checks++; if (r_ld !== t_en + 3) begin errors++; $display("FAIL lat_load got=%0d exp=%0d", r_ld, t_en + 3); end
        checks++; if (r_wr !== t_en + 3 + P) begin errors++; $display("FAIL lat_wren got=%0d exp=%0d", r_wr, t_en + 3 + P); end
        checks++; if (r_wa !== 0) begin errors++; $display("FAIL lat_waddr got=%0d exp=0", r_wa); end
    endtask

    task automatic test_full_frame();
        int q[$];
        int fd_cnt = 0, fd_at = -1, addr_at_fd = -1, bad_gap = 0, pre_fd = 0;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            if (smp_ready) begin
                q.push_back(now);
                if (fd_at < 0) pre_fd++;
            end
            if (frame_done) begin
                fd_cnt++;
                if (fd_at < 0) begin fd_at = now; addr_at_fd = int'(smp_addr); end
            end
        end
        for (int k = 1; k < q.size(); k++) if (q[k] - q[k-1] != SC) bad_gap++;
        checks++; if (pre_fd !== N + 1) begin errors++; $display("FAIL frame_ready_count got=%0d exp=%0d", pre_fd, N + 1); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL frame_spacing bad_gaps=%0d exp=0", bad_gap); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
        checks++; if (q.size() < N + 1 || fd_at !== q[0] + N * SC + 1) begin
            errors++; $display("FAIL frame_done_time got=%0d exp_after_first=%0d", fd_at, N * SC + 1); end
        checks++; if (addr_at_fd !== N) begin errors++; $display("FAIL frame_addr got=%0d exp=%0d", addr_at_fd, N); end
        checks++; if (q.size() < N + 1 || q[N] !== q[0] + N * SC) begin
            errors++; $display("FAIL frame_no_bubble got_size=%0d exp_next_at=+%0d", q.size(), N * SC); end
    endtask

    task automatic test_wait_stall();
        int q[$];
        int stall = 0, ra7 = -1;
        bit vld;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            vld = 1'b1;
            if (m_issued == 7 && stall < 5 && now + 1 >= m_next_ok) begin vld = 1'b0; stall++; end
            run_cycle(1'b1, vld, 1'b0);
            if (!vld) begin
                checks++; if ({lif_load, wren, smp_ready, busy} !== 4'b0001) begin
                    errors++; $display("FAIL stall_quiet cyc=%0d got=%b exp=0001", now, {lif_load, wren, smp_ready, busy}); end
            end
            if (smp_ready) q.push_back(now);
            if (q.size() == 8 && now == q[7] + 1) ra7 = int'(raddr);
        end
        checks++; if (q.size() < 8 || q[7] - q[6] !== SC + 5) begin
            errors++; $display("FAIL stall_gap got_size=%0d exp_gap=%0d", q.size(), SC + 5); end
        checks++; if (ra7 !== 7) begin errors++; $display("FAIL stall_raddr got=%0d exp=7", ra7); end
    endtask

    task automatic test_spike();
        int w12 = -1, sp_cnt = 0, sp_at = -1, sp_ch = -1;
        bit spk;
        do_reset();
        for (int i = 0; i < 820; i++) begin
            spk = (m_wb_at == now + 1) && (m_cur_ch == 12);
            run_cycle(1'b1, 1'b1, spk);
            if (wren && waddr == 10'd12) w12 = now;
            if (spike_valid) begin sp_cnt++; sp_at = now; sp_ch = int'(spike_ch); end
        end
        checks++; if (sp_cnt !== 1) begin errors++; $display("FAIL spike_count got=%0d exp=1", sp_cnt); end
        checks++; if (sp_ch !== 12) begin errors++; $display("FAIL spike_ch got=%0d exp=12", sp_ch); end
        checks++; if (w12 < 0 || sp_at !== w12 + 1) begin errors++; $display("FAIL spike_lag got=%0d exp=%0d", sp_at, w12 + 1); end
    endtask

    task automatic test_enable_drop();
        int rdy = 0, lds = 0, wrs = 0, fd_cnt = 0, fd_at = -1, post_rdy = 0, post_busy = 0, busy_fd = -1;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            run_cycle(m_issued <= 20, 1'b1, 1'b0);
            if (smp_ready) rdy++;
            if (lif_load) lds++;
            if (wren) wrs++;
            if (frame_done) begin fd_cnt++; fd_at = now; busy_fd = int'(busy); end
            if (fd_at >= 0 && now > fd_at) begin
                if (smp_ready) post_rdy++;
                if (busy) post_busy++;
            end
        end
        checks++; if (rdy !== N) begin errors++; $display("FAIL drop_ready_count got=%0d exp=%0d", rdy, N); end
        checks++; if ({lds, wrs} !== {N, N}) begin errors++; $display("FAIL drop_load_wren got=%0d/%0d exp=%0d", lds, wrs, N); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL drop_frame_done got=%0d exp=1", fd_cnt); end
        checks++; if (busy_fd !== 0) begin errors++; $display("FAIL drop_busy got=%0d exp=0", busy_fd); end
        checks++; if ({post_rdy, post_busy} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL drop_after got_ready=%0d got_busy=%0d exp=0", post_rdy, post_busy); end
    endtask

    task automatic test_wrap_and_reset();
        int prev = 0;
        bit seen_wrap = 1'b0, hit = 1'b0;
        do_reset();
        for (int i = 0; i < 1700; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            checks++; if (w_smp_addr !== e_addr_w) begin
                errors++; $display("FAIL wrap_addr cyc=%0d got=%0d exp=%0d", now, w_smp_addr, e_addr_w); end
            checks++; if ({w_smp_ready, w_lif_load, w_wren, w_frame_done, w_busy, w_raddr, w_waddr, w_spike_valid, w_spike_ch}
                       !== {e_ready, e_load, e_wren, e_fd, e_busy, e_raddr, e_waddr, e_spk, e_spk_ch}) begin
                errors++; $display("FAIL wrap_outputs cyc=%0d got=%h exp=%h", now,
                    {w_smp_ready, w_lif_load, w_wren, w_frame_done, w_busy, w_raddr, w_waddr, w_spike_valid, w_spike_ch},
                    {e_ready, e_load, e_wren, e_fd, e_busy, e_raddr, e_waddr, e_spk, e_spk_ch}); end
            if (prev == DEPTH_W - 1 && w_smp_addr == 24'd0) seen_wrap = 1'b1;
            prev = int'(w_smp_addr);
        end
        checks++; if (seen_wrap !== 1'b1) begin errors++; $display("FAIL wrap_seen got=%b exp=1", seen_wrap); end
        for (int i = 0; i < 40 && !hit; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            if (now == m_load_at + 1) hit = 1'b1;
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midslot_reach got=%b exp=1", hit); end
        reset = 1'b1;
        #1;
        checks++; if ({smp_ready, lif_load, wren, spike_valid, frame_done, busy, smp_addr, raddr, waddr, spike_ch} !== '0) begin
            errors++; $display("FAIL midslot_reset got=%h exp=0",
                {smp_ready, lif_load, wren, spike_valid, frame_done, busy, smp_addr, raddr, waddr, spike_ch}); end
        @(posedge clk_in);
        #1;
        reset = 1'b0; enable = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0);
            checks++; if ({wren, smp_ready, busy} !== 3'b000) begin
                errors++; $display("FAIL post_reset_quiet cyc=%0d got=%b exp=000", now, {wren, smp_ready, busy}); end
        end
    endtask

    task automatic test_random();
        bit en, vld, spk;
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            vld = ($urandom_range(0, 9) < 8);
            spk = $urandom_range(0, 1) == 1;
            run_cycle(en, vld, spk);
            checks++; if (smp_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", now, smp_ready, e_ready); end
            checks++; if (lif_load !== e_load) begin errors++; $display("FAIL rnd_load cyc=%0d got=%b exp=%b", now, lif_load, e_load); end
            checks++; if ({wren, waddr} !== {e_wren, e_waddr}) begin
                errors++; $display("FAIL rnd_wren cyc=%0d got=%b/%0d exp=%b/%0d", now, wren, waddr, e_wren, e_waddr); end
            checks++; if (raddr !== e_raddr) begin errors++; $display("FAIL rnd_raddr cyc=%0d got=%0d exp=%0d", now, raddr, e_raddr); end
            checks++; if (smp_addr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", now, smp_addr, e_addr); end
            checks++; if ({spike_valid, spike_ch} !== {e_spk, e_spk_ch}) begin
                errors++; $display("FAIL rnd_spike cyc=%0d got=%b/%0d exp=%b/%0d", now, spike_valid, spike_ch, e_spk, e_spk_ch); end
            checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL rnd_frame_done cyc=%0d got=%b exp=%b", now, frame_done, e_fd); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", now, busy, e_busy); end
            checks++; if (w_smp_addr !== e_addr_w) begin errors++; $display("FAIL rnd_addr_w cyc=%0d got=%0d exp=%0d", now, w_smp_addr, e_addr_w); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_latency();
        test_full_frame();
        test_wait_stall();
        test_spike();
        test_enable_drop();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
